// File: rtl/mti_two_pulse_canceller.sv
// Purpose: two-pulse MTI canceller; per range bin outputs current-minus-previous-pulse I/Q.
// Latency: 1 cycle from an accepted in_valid to out_valid / ovf.
// Backpressure: none; accepts one sample per cycle, excess samples in a PRI are dropped with ovf.
module mti_two_pulse_canceller #(
    parameter int WIDTH = 12,
    parameter int NBINS = 256,
    parameter int BIN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prt_start,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] in_q,
    output logic                    out_valid,
    output logic signed [WIDTH:0]   out_i,
    output logic signed [WIDTH:0]   out_q,
    output logic [BIN_W-1:0]        out_bin,
    output logic                    ovf
);

    // Counter is one bit wider than the bin index so it can sit at NBINS.
    localparam logic [BIN_W:0] NB  = (BIN_W+1)'(NBINS);
    localparam logic [BIN_W:0] ONE = (BIN_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_eff;
    state_t                 w_state_nxt;
    logic [BIN_W:0]         r_bin_cnt;
    logic [BIN_W:0]         w_bin_eff;
    logic [BIN_W:0]         w_bin_cnt_nxt;
    logic [BIN_W-1:0]       w_bin;
    logic                   w_active;
    logic                   w_accept;
    logic                   w_overrun;
    logic                   w_emit;

    logic [NBINS-1:0]       r_seen;
    logic [2*WIDTH-1:0]     r_mem [NBINS];
    logic [2*WIDTH-1:0]     r_prev;
    logic [2*WIDTH-1:0]     r_cur;
    logic [BIN_W-1:0]       r_out_bin;
    logic                   r_out_vld;
    logic                   r_ovf;
    logic signed [WIDTH:0]  w_diff_i;
    logic signed [WIDTH:0]  w_diff_q;

    // State and bin counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bin_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bin_cnt <= w_bin_cnt_nxt;
        end
    end

    // A prt_start applies to a coincident sample, so decode from the post-strobe state and bin.
    always_comb begin
        w_state_eff   = r_state;
        w_bin_eff     = r_bin_cnt;
        w_active      = 1'b0;
        w_accept      = 1'b0;
        w_overrun     = 1'b0;
        w_emit        = 1'b0;
        if (prt_start) begin
            w_bin_eff = '0;
            case (r_state)
                S_IDLE:  w_state_eff = S_FILL;
                default: w_state_eff = S_RUN;
            endcase
        end
        w_bin         = w_bin_eff[BIN_W-1:0];
        w_active      = in_valid && (w_state_eff != S_IDLE);
        w_accept      = w_active && (w_bin_eff < NB);
        w_overrun     = w_active && (w_bin_eff >= NB);
        w_emit        = w_accept && (w_state_eff == S_RUN) && r_seen[w_bin];
        w_state_nxt   = w_state_eff;
        w_bin_cnt_nxt = w_accept ? (w_bin_eff + ONE) : w_bin_eff;
    end

    // Per-bin flag: the bin holds data from an earlier pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= '0;
        end else if (w_accept) begin
            r_seen[w_bin] <= 1'b1;
        end
    end

    // History memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_bin] <= {in_i, in_q};
        end
    end

    // Registered read; same-bin write in this cycle still returns the old pulse's value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else if (w_emit) begin
            r_prev <= r_mem[w_bin];
        end
    end

    // Output-side pipeline; data registers only move when a difference is produced, so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur     <= '0;
            r_out_bin <= '0;
            r_out_vld <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_out_vld <= w_emit;
            r_ovf     <= w_overrun;
            if (w_emit) begin
                r_cur     <= {in_i, in_q};
                r_out_bin <= w_bin;
            end
        end
    end

    // Full-precision difference of the sign-extended current and previous samples.
    always_comb begin
        w_diff_i = $signed({r_cur[2*WIDTH-1], r_cur[2*WIDTH-1:WIDTH]})
                 - $signed({r_prev[2*WIDTH-1], r_prev[2*WIDTH-1:WIDTH]});
        w_diff_q = $signed({r_cur[WIDTH-1], r_cur[WIDTH-1:0]})
                 - $signed({r_prev[WIDTH-1], r_prev[WIDTH-1:0]});
    end

    // Outputs are forced quiet while reset is held, which also kills a result pending from the prior cycle.
    assign out_valid = r_out_vld & ~rst;
    assign ovf       = r_ovf & ~rst;
    assign out_i     = rst ? '0 : w_diff_i;
    assign out_q     = rst ? '0 : w_diff_q;
    assign out_bin   = rst ? '0 : r_out_bin;

endmodule

// File: tb/tb_mti_two_pulse_canceller.sv
// Purpose: self-checking bench for mti_two_pulse_canceller (directed scenarios plus random traffic vs a model).
// Latency: expects results one clock after each sample.
// Backpressure: none; stimulus may present a sample every cycle.
module tb_mti_two_pulse_canceller;

    localparam int W  = 12;
    localparam int NB = 4;
    localparam int BW = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 prt_start = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [W-1:0]  in_i = '0;
    logic signed [W-1:0]  in_q = '0;
    logic                 out_valid;
    logic signed [W:0]    out_i;
    logic signed [W:0]    out_q;
    logic [BW-1:0]        out_bin;
    logic                 ovf;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: previous-pulse table per bin plus the expected output registers.
    int m_mode;             // 0 idle, 1 first pulse, 2 cancelling
    int m_cnt;
    int m_mem_i [NB];
    int m_mem_q [NB];
    bit m_seen  [NB];
    bit e_vld, e_ovf;
    int e_i, e_q, e_bin;

    mti_two_pulse_canceller #(.WIDTH(W), .NBINS(NB), .BIN_W(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .prt_start (prt_start),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_bin   (out_bin),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model consumes the same inputs at the edge.
    task automatic tick(input bit p, input bit v, input int i, input int q);
        prt_start = p;
        in_valid  = v;
        in_i      = W'(i);
        in_q      = W'(q);
        @(posedge clk);
        e_vld = 1'b0;
        e_ovf = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_cnt  = 0;
            for (int b = 0; b < NB; b++) m_seen[b] = 1'b0;
            e_i = 0; e_q = 0; e_bin = 0;
        end else begin
            if (p) begin
                m_mode = (m_mode == 0) ? 1 : 2;
                m_cnt  = 0;
            end
            if (v && m_mode != 0) begin
                if (m_cnt < NB) begin
                    if (m_mode == 2 && m_seen[m_cnt]) begin
                        e_vld = 1'b1;
                        e_i   = i - m_mem_i[m_cnt];
                        e_q   = q - m_mem_q[m_cnt];
                        e_bin = m_cnt;
                    end
                    m_mem_i[m_cnt] = i;
                    m_mem_q[m_cnt] = q;
                    m_seen[m_cnt]  = 1'b1;
                    m_cnt++;
                end else begin
                    e_ovf = 1'b1;
                end
            end
        end
        #1;
        prt_start = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1, 1, 77, 77);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", out_valid); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_chk++; if (out_i !== '0 || out_q !== '0) begin n_fail++; $display("FAIL rst_data: got i=%0d q=%0d want 0 0", out_i, out_q); end
        n_chk++; if (out_bin !== '0) begin n_fail++; $display("FAIL rst_bin: got %0d want 0", out_bin); end
        rst = 1'b0;
        // Samples in IDLE are ignored: no output, no overflow.
        for (int k = 0; k < 6; k++) begin
            tick(0, 1, 9, 9);
            n_chk++; if (out_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL idle_ignore k%0d: got vld=%b ovf=%b want 0 0", k, out_valid, ovf); end
        end
    endtask

    task automatic test_zero_clutter();
        do_reset();
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 100, -50);
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zc_fill k%0d: got vld=%b want 0", k, out_valid); end
        end
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 100, -50);
            n_chk++;
            if (out_valid !== 1'b1 || out_i !== '0 || out_q !== '0 || out_bin !== BW'(k)) begin
                n_fail++;
                $display("FAIL zc_run k%0d: got vld=%b i=%0d q=%0d bin=%0d want 1 0 0 %0d", k, out_valid, out_i, out_q, out_bin, k);
            end
        end
        tick(0, 0, 0, 0);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zc_pulse: got vld=%b want 0", out_valid); end
    endtask

    task automatic test_extremes();
        do_reset();
        tick(1, 1, 2047, -2048);
        tick(1, 1, -2048, 2047);
        n_chk++;
        if (out_valid !== 1'b1 || out_i !== -13'sd4095 || out_q !== 13'sd4095) begin
            n_fail++;
            $display("FAIL extremes: got vld=%b i=%0d q=%0d want 1 -4095 4095", out_valid, out_i, out_q);
        end
        tick(0, 0, 0, 0);
        n_chk++; if (out_i !== -13'sd4095 || out_q !== 13'sd4095) begin n_fail++; $display("FAIL extremes_hold: got i=%0d q=%0d want -4095 4095", out_i, out_q); end
    endtask

    task automatic test_overflow();
        int vi [6];
        int vq [6];
        int a, b;
        do_reset();
        tick(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            vi[k] = int'($urandom_range(0, 4095)) - 2048;
            vq[k] = int'($urandom_range(0, 4095)) - 2048;
            tick(0, 1, vi[k], vq[k]);
            n_chk++;
            if (ovf !== (k >= 4) || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_pulse k%0d: got ovf=%b vld=%b want %0d 0", k, ovf, out_valid, (k >= 4));
            end
        end
        tick(0, 0, 0, 0);
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            a = int'($urandom_range(0, 4095)) - 2048;
            b = int'($urandom_range(0, 4095)) - 2048;
            tick(0, 1, a, b);
            n_chk++;
            if (out_valid !== 1'b1 || out_bin !== BW'(k) || out_i !== (W+1)'(a - vi[k]) || out_q !== (W+1)'(b - vq[k])) begin
                n_fail++;
                $display("FAIL ovf_mem k%0d: got vld=%b bin=%0d i=%0d q=%0d want 1 %0d %0d %0d", k, out_valid, out_bin, out_i, out_q, k, a - vi[k], b - vq[k]);
            end
        end
    endtask

    task automatic test_short_pri();
        int v;
        do_reset();
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 2, 0);
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            v = (k < 2) ? 10 : 7;
            tick(0, 1, v, 0);
            n_chk++;
            if (out_valid !== (k < 2) || (k < 2 && out_i !== (W+1)'(10 - (k + 1)))) begin
                n_fail++;
                $display("FAIL short2 k%0d: got vld=%b i=%0d want %0d %0d", k, out_valid, out_i, (k < 2), 10 - (k + 1));
            end
        end
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 7, 0);
            v = (k < 2) ? -3 : 0;
            n_chk++;
            if (out_valid !== 1'b1 || out_i !== (W+1)'(v) || out_bin !== BW'(k)) begin
                n_fail++;
                $display("FAIL short3 k%0d: got vld=%b i=%0d bin=%0d want 1 %0d %0d", k, out_valid, out_i, out_bin, v, k);
            end
        end
    endtask

    task automatic test_coincident();
        do_reset();
        tick(1, 1, 3, -1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_fill: got vld=%b want 0", out_valid); end
        tick(1, 1, 5, 4);
        n_chk++;
        if (out_valid !== 1'b1 || out_bin !== '0 || out_i !== 13'sd2 || out_q !== 13'sd5) begin
            n_fail++;
            $display("FAIL coinc_run: got vld=%b bin=%0d i=%0d q=%0d want 1 0 2 5", out_valid, out_bin, out_i, out_q);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 1);
        tick(0, 1, 2, 2);
        tick(1, 0, 0, 0);
        tick(0, 1, 5, 5);
        n_chk++; if (out_valid !== 1'b1 || out_i !== 13'sd4) begin n_fail++; $display("FAIL rmid_pre: got vld=%b i=%0d want 1 4", out_valid, out_i); end
        tick(0, 1, 6, 6);
        rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0 || out_i !== '0) begin n_fail++; $display("FAIL rmid_suppress: got vld=%b i=%0d want 0 0", out_valid, out_i); end
        tick(0, 0, 0, 0);
        rst = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got vld=%b want 0", out_valid); end
        tick(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 40, 40);
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_fill k%0d: got vld=%b want 0", k, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        bit p, v;
        int i, q;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            p = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 3) != 0);
            i = int'($urandom_range(0, 4095)) - 2048;
            q = int'($urandom_range(0, 4095)) - 2048;
            tick(p, v, i, q);
            n_chk++;
            if (out_valid !== e_vld || ovf !== e_ovf || out_i !== (W+1)'(e_i) || out_q !== (W+1)'(e_q) || out_bin !== BW'(e_bin)) begin
                n_fail++;
                $display("FAIL random c%0d: got vld=%b ovf=%b i=%0d q=%0d bin=%0d want %b %b %0d %0d %0d",
                         c, out_valid, ovf, out_i, out_q, out_bin, e_vld, e_ovf, e_i, e_q, e_bin);
            end
        end
    endtask

    initial begin
        m_mode = 0; m_cnt = 0;
        e_vld = 0; e_ovf = 0; e_i = 0; e_q = 0; e_bin = 0;
        for (int b = 0; b < NB; b++) begin
            m_seen[b] = 1'b0; m_mem_i[b] = 0; m_mem_q[b] = 0;
        end
        #2;
        test_reset();
        test_zero_clutter();
        test_extremes();
        test_overflow();
        test_short_pri();
        test_coincident();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
